// File: rtl/lab_readout_sched.sv
// rtl/lab_readout_sched.sv - four-LAB trigger hold, round-robin digitize/readout scheduler with 4-entry output FIFO
module lab_readout_sched #(
  parameter int NWORDS     = 1024,
  parameter int RD_LAT     = 1,
  parameter int DONE_BLANK = 8,
  parameter int TIMEOUT    = 1 << 20
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        enable_i,
  input  logic [3:0]  trig_i,
  output logic [3:0]  hold_o,
  output logic [3:0]  digitize_o,
  output logic [12:0] lab_addr_o,
  input  logic [31:0] lab_dat_i,
  input  logic        lab_done_i,
  output logic [31:0] out_dat_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        out_last_o,
  output logic        busy_o,
  output logic        err_timeout_o,
  input  logic        clr_err_i
);

  typedef enum logic [2:0] {S_IDLE, S_DIG, S_WAIT, S_HDR, S_READ, S_DRAIN, S_REL} state_t;

  // wait_cnt counts cycles since the digitize pulse, so the blanking window and the
  // timeout (which only starts once blanking ends) share one counter.
  localparam logic [31:0] BLANK_LIM = 32'(DONE_BLANK);
  localparam logic [31:0] TO_LIM    = 32'(DONE_BLANK + TIMEOUT - 1);
  localparam logic [11:0] NW        = 12'(NWORDS);

  state_t      state;
  logic [1:0]  cur;
  logic [1:0]  ptr;
  logic [15:0] evcnt;
  logic [31:0] wait_cnt;
  logic [11:0] next_a;
  logic [2:0]  inflight;
  logic [RD_LAT:0] pipe_v;
  logic [RD_LAT:0] pipe_l;

  logic [31:0] fifo_dat [4];
  logic [3:0]  fifo_last;
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  count;

  logic [1:0]  pick;
  logic [3:0]  rel_mask;
  logic        issue;
  logic        land;
  logic        hdr_push;
  logic        push;
  logic        pop;
  logic [31:0] push_dat;
  logic        push_last;

  // Round-robin pick: scan offsets 3..0 so the held LAB closest to ptr wins.
  always_comb begin
    pick = ptr;
    for (int i = 3; i >= 0; i--) begin
      if (hold_o[ptr + 2'(i)]) pick = ptr + 2'(i);
    end
  end

  // Reads in flight plus buffered words never exceed the FIFO depth, so landing data always fits.
  assign issue     = (state == S_READ) && (next_a < NW) &&
                     (({1'b0, count} + {1'b0, inflight}) < 4'd4);
  assign land      = pipe_v[RD_LAT];
  assign hdr_push  = (state == S_HDR) && (count < 3'd4);
  assign push      = hdr_push | land;
  assign push_dat  = hdr_push ? {8'hA5, 6'd0, cur, evcnt} : lab_dat_i;
  assign push_last = hdr_push ? 1'b0 : pipe_l[RD_LAT];
  assign pop       = out_valid_o & out_ready_i;
  assign rel_mask  = (state == S_REL) ? (4'b0001 << cur) : 4'b0000;

  assign out_valid_o = (count != 3'd0);
  assign out_dat_o   = fifo_dat[rd_ptr];
  assign out_last_o  = out_valid_o & fifo_last[rd_ptr];
  assign busy_o      = (state != S_IDLE);

  // Read-latency pipeline: each issued address carries a token that lands RD_LAT cycles later.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pipe_v   <= '0;
      pipe_l   <= '0;
      inflight <= '0;
    end else begin
      pipe_v[0] <= issue;
      pipe_l[0] <= issue && (next_a == NW - 12'd1);
      for (int k = 1; k <= RD_LAT; k++) begin
        pipe_v[k] <= pipe_v[k-1];
        pipe_l[k] <= pipe_l[k-1];
      end
      inflight <= inflight + {2'b0, issue} - {2'b0, land};
    end
  end

  // Output FIFO: header and landed words in, host stream out.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fifo_dat  <= '{default: '0};
      fifo_last <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      if (push) begin
        fifo_dat[wr_ptr]  <= push_dat;
        fifo_last[wr_ptr] <= push_last;
        wr_ptr            <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b0, push} - {2'b0, pop};
    end
  end

  // Event FSM with trigger latch, error flag and address port.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state         <= S_IDLE;
      cur           <= '0;
      ptr           <= '0;
      evcnt         <= '0;
      wait_cnt      <= '0;
      next_a        <= '0;
      hold_o        <= '0;
      digitize_o    <= '0;
      lab_addr_o    <= '0;
      err_timeout_o <= 1'b0;
    end else begin
      hold_o     <= (hold_o | (trig_i & {4{enable_i}})) & ~rel_mask;
      digitize_o <= '0;
      if (clr_err_i) err_timeout_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|hold_o) begin
            cur        <= pick;
            lab_addr_o <= {pick, 11'd0};
            digitize_o <= 4'b0001 << pick;
            state      <= S_DIG;
          end
        end
        S_DIG: begin
          wait_cnt <= 32'd1;
          next_a   <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt >= BLANK_LIM && lab_done_i) begin
            state <= S_HDR;
          end else if (wait_cnt >= TO_LIM) begin
            err_timeout_o <= 1'b1;
            state         <= S_REL;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        S_HDR: begin
          if (hdr_push) state <= S_READ;
        end
        S_READ: begin
          if (issue) begin
            lab_addr_o[10:0] <= next_a[10:0];
            next_a           <= next_a + 12'd1;
          end else if (next_a == NW && inflight == 3'd0) begin
            lab_addr_o[10:0] <= '0;
            state            <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (count == 3'd0) state <= S_REL;
        end
        S_REL: begin
          ptr   <= cur + 2'd1;
          evcnt <= evcnt + 16'd1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
